// File: rtl/adder_vector_sequencer_pkg.sv
// Shared types and widths for the adder vector sequencer.
//   state_e      : sequencer FSM states
//   VEC_W/OUT_W  : stimulus vector width / adder result width {carry,sum}
//   ERR_W        : failing-vector counter width (holds 0..8)
//   NUM_IMPL     : number of adder implementations compared
//   TIMER_W      : settle timer width (SETTLE_CYCLES up to 15)
package adder_vector_sequencer_pkg;

  localparam int unsigned VEC_W    = 3;
  localparam int unsigned OUT_W    = 2;
  localparam int unsigned ERR_W    = 4;
  localparam int unsigned NUM_IMPL = 3;
  localparam int unsigned TIMER_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  // Reference full-adder result {carry,sum} for vector {a,b,c}.
  function automatic logic [OUT_W-1:0] expected_sum(input logic [VEC_W-1:0] v);
    return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/adder_vector_sequencer_if.sv
// Bus between the sequencer and the adders under check.
//   master : sequencer side (drives a/b/c and results, receives start and y_*)
//   slave  : environment side (drives start and y_*, observes the rest)
interface adder_vector_sequencer_if;
  import adder_vector_sequencer_pkg::*;

  logic                start;
  logic                a;
  logic                b;
  logic                c;
  logic [OUT_W-1:0]    y_tr;
  logic [OUT_W-1:0]    y_gate;
  logic [OUT_W-1:0]    y_assign;
  logic                busy;
  logic                done;
  logic                pass;
  logic [ERR_W-1:0]    err_count;
  logic [NUM_IMPL-1:0] impl_fail;
  logic [VEC_W-1:0]    first_fail_vec;
  logic                fail_valid;

  modport master (
    input  start, y_tr, y_gate, y_assign,
    output a, b, c, busy, done, pass, err_count, impl_fail, first_fail_vec, fail_valid
  );

  modport slave (
    output start, y_tr, y_gate, y_assign,
    input  a, b, c, busy, done, pass, err_count, impl_fail, first_fail_vec, fail_valid
  );

endinterface

// File: rtl/adder_vector_sequencer_settle_timer.sv
// Loadable down-counter that holds each vector for its settle time.
//   clk, rst : clock, asynchronous active-high reset
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one, stopping at zero
//   zero     : count is zero
module adder_vector_sequencer_settle_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/adder_vector_sequencer.sv
// Walks {a,b,c} through 000..111, holds each vector SETTLE_CYCLES cycles,
// then compares the three adder implementations against a+b+c and records
// failures.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : master side of adder_vector_sequencer_if
//              start in; a/b/c stimulus out; y_tr/y_gate/y_assign in;
//              busy, done, pass, err_count, impl_fail, first_fail_vec,
//              fail_valid out
module adder_vector_sequencer
  import adder_vector_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic                      clk,
  input logic                      rst,
  adder_vector_sequencer_if.master bus
);

  localparam logic [TIMER_W-1:0] Reload  = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0]   LastVec = '1;

  state_e              state_q, state_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [NUM_IMPL-1:0] impl_fail_q, impl_fail_d;
  logic [VEC_W-1:0]    first_q, first_d;
  logic                fail_valid_q, fail_valid_d;

  logic                timer_load, timer_dec, timer_zero;
  logic [OUT_W-1:0]    expected;
  logic [NUM_IMPL-1:0] mismatch;

  adder_vector_sequencer_settle_timer #(
    .Width (TIMER_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (Reload),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  assign expected = expected_sum(vec_q);
  assign mismatch = {bus.y_assign != expected, bus.y_gate != expected, bus.y_tr != expected};

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    err_d        = err_q;
    impl_fail_d  = impl_fail_q;
    first_d      = first_q;
    fail_valid_d = fail_valid_q;
    timer_load   = 1'b0;
    timer_dec    = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d      = StSettle;
          vec_d        = '0;
          err_d        = '0;
          impl_fail_d  = '0;
          first_d      = '0;
          fail_valid_d = 1'b0;
          timer_load   = 1'b1;
        end
      end
      StSettle: begin
        if (timer_zero) begin
          state_d = StSample;
        end else begin
          timer_dec = 1'b1;
        end
      end
      StSample: begin
        // At most one increment per vector, so err never exceeds 8.
        if (|mismatch) begin
          err_d       = err_q + ERR_W'(1);
          impl_fail_d = impl_fail_q | mismatch;
          if (!fail_valid_q) begin
            first_d      = vec_q;
            fail_valid_d = 1'b1;
          end
        end
        if (vec_q != LastVec) begin
          vec_d      = vec_q + VEC_W'(1);
          timer_load = 1'b1;
          state_d    = StSettle;
        end else begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      vec_q        <= '0;
      err_q        <= '0;
      impl_fail_q  <= '0;
      first_q      <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      err_q        <= err_d;
      impl_fail_q  <= impl_fail_d;
      first_q      <= first_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign bus.a              = vec_q[2];
  assign bus.b              = vec_q[1];
  assign bus.c              = vec_q[0];
  assign bus.busy           = (state_q == StSettle) || (state_q == StSample);
  assign bus.done           = (state_q == StDone);
  assign bus.pass           = (state_q == StDone) && (err_q == '0);
  assign bus.err_count      = err_q;
  assign bus.impl_fail      = impl_fail_q;
  assign bus.first_fail_vec = first_q;
  assign bus.fail_valid     = fail_valid_q;

endmodule

// File: tb/tb_adder_vector_sequencer.sv
// Bench for adder_vector_sequencer: one instance with SETTLE_CYCLES=4 fed by
// an adder model with selectable faults, one with SETTLE_CYCLES=1 fed by an
// ideal model. Expected run results are queued at start and checked at done.
module tb_adder_vector_sequencer;
  import adder_vector_sequencer_pkg::*;

  typedef struct {
    int unsigned err;
    int unsigned impl;
    int unsigned first;
    int unsigned fv;
    int unsigned pass;
  } result_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic sel = 1'b0;
  int   fault_mode = 0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  result_t     exp_q[$];

  adder_vector_sequencer_if bus ();
  adder_vector_sequencer_if bus1 ();

  adder_vector_sequencer #(.SETTLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  adder_vector_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  always #5 clk = ~clk;

  // Adder models: ideal, gate returns 00 at vector 011, or tr carry stuck at 0.
  logic [1:0] sum0, y_tr, y_gate, y_assign;
  always_comb begin
    sum0     = {1'b0, bus.a} + {1'b0, bus.b} + {1'b0, bus.c};
    y_tr     = sum0;
    y_gate   = sum0;
    y_assign = sum0;
    if (fault_mode == 1 && {bus.a, bus.b, bus.c} == 3'b011) y_gate = 2'b00;
    if (fault_mode == 2) y_tr[1] = 1'b0;
  end

  assign bus.start     = start0;
  assign bus.y_tr      = y_tr;
  assign bus.y_gate    = y_gate;
  assign bus.y_assign  = y_assign;
  assign bus1.start    = start1;
  assign bus1.y_tr     = {1'b0, bus1.a} + {1'b0, bus1.b} + {1'b0, bus1.c};
  assign bus1.y_gate   = {1'b0, bus1.a} + {1'b0, bus1.b} + {1'b0, bus1.c};
  assign bus1.y_assign = {1'b0, bus1.a} + {1'b0, bus1.b} + {1'b0, bus1.c};

  // Observed signals of whichever instance is under test.
  logic [2:0] mon_abc, mon_impl, mon_first;
  logic [3:0] mon_err;
  logic       mon_busy, mon_done, mon_pass, mon_fv;
  always_comb begin
    mon_abc   = sel ? {bus1.a, bus1.b, bus1.c} : {bus.a, bus.b, bus.c};
    mon_busy  = sel ? bus1.busy : bus.busy;
    mon_done  = sel ? bus1.done : bus.done;
    mon_pass  = sel ? bus1.pass : bus.pass;
    mon_err   = sel ? bus1.err_count : bus.err_count;
    mon_impl  = sel ? bus1.impl_fail : bus.impl_fail;
    mon_first = sel ? bus1.first_fail_vec : bus.first_fail_vec;
    mon_fv    = sel ? bus1.fail_valid : bus.fail_valid;
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  function automatic result_t model_run(input int mode);
    result_t     r;
    logic  [1:0] s, t, g, y;
    r = '{err: 0, impl: 0, first: 0, fv: 0, pass: 0};
    for (int v = 0; v < 8; v++) begin
      s = 2'(((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1));
      t = s;
      g = s;
      y = s;
      if (mode == 1 && v == 3) g = 2'b00;
      if (mode == 2) t[1] = 1'b0;
      if (t != s || g != s || y != s) begin
        r.err++;
        if (t != s) r.impl |= 1;
        if (g != s) r.impl |= 2;
        if (y != s) r.impl |= 4;
        if (r.fv == 0) begin
          r.first = v;
          r.fv    = 1;
        end
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    return r;
  endfunction

  // One full run: queue expectation, start (also releasing rst), follow the
  // vector sequence, then compare the final results at done.
  task automatic run_seq(input int unsigned settle, input bit spam);
    int unsigned k, limit, hold;
    bit          seen;
    result_t     r;
    hold  = settle + 1;
    limit = 8 * hold + 20;
    exp_q.push_back(model_run(sel ? 0 : fault_mode));
    @(negedge clk);
    rst = 1'b0;
    drive_start(1'b1);
    @(posedge clk);
    #1;
    if (!spam) drive_start(1'b0);
    check_eq("busy_after_start", mon_busy, 1);
    check_eq("vec_first", mon_abc, 0);
    k    = 0;
    seen = 0;
    while (!seen && k < limit) begin
      @(posedge clk);
      #1;
      k++;
      if (mon_done) seen = 1;
      else check_eq("vec_seq", mon_abc, k / hold);
    end
    drive_start(1'b0);
    check_eq("done_latency", k, 8 * hold);
    check_eq("busy_in_done", mon_busy, 0);
    check_eq("vec_held_7", mon_abc, 7);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 1, 0);
    end else begin
      r = exp_q.pop_front();
      check_eq("err_count", mon_err, r.err);
      check_eq("impl_fail", mon_impl, r.impl);
      check_eq("first_fail_vec", mon_first, r.first);
      check_eq("fail_valid", mon_fv, r.fv);
      check_eq("pass", mon_pass, r.pass);
      repeat (3) @(posedge clk);
      #1;
      check_eq("done_held", mon_done, 1);
      check_eq("err_count_stable", mon_err, r.err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_abc", mon_abc, 0);
    check_eq("rst_busy", mon_busy, 0);
    check_eq("rst_done", mon_done, 0);
    check_eq("rst_pass", mon_pass, 0);
    check_eq("rst_err", mon_err, 0);
    check_eq("rst_impl", mon_impl, 0);
    check_eq("rst_first", mon_first, 0);
    check_eq("rst_fv", mon_fv, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("idle_no_start", mon_busy, 0);

    fault_mode = 0;
    run_seq(4, 1'b0);
    fault_mode = 1;
    run_seq(4, 1'b0);
    fault_mode = 2;
    run_seq(4, 1'b0);
    fault_mode = 0;
    run_seq(4, 1'b1);

    // Abort a faulty run at vector 101 and confirm nothing survives.
    fault_mode = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0  = 1'b0;
    reached = 0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(posedge clk);
      #1;
      if (mon_abc == 3'b101) reached = 1;
    end
    check_eq("reach_vec5", reached, 1);
    check_eq("err_before_abort", mon_err, 1);
    rst = 1'b1;
    #1;
    check_eq("abort_abc", mon_abc, 0);
    check_eq("abort_busy", mon_busy, 0);
    check_eq("abort_err", mon_err, 0);
    check_eq("abort_fv", mon_fv, 0);
    check_eq("abort_impl", mon_impl, 0);
    fault_mode = 0;
    run_seq(4, 1'b0);

    sel = 1'b1;
    run_seq(1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
